matmul_dot_sched: RTL

Sequencer that drives one shared `vec_dot` instance through a full M×N output tile of a matrix product. It walks output indices in row-major order, one dot product per cycle, and tracks each issued index through the fixed-latency `vec_dot` pipeline. It buffers results in a small output FIFO and presents them on a valid/ready stream. `vec_dot` has no stall input, so the block uses credits to guarantee that no result is lost under back-pressure.

---
 rtl/matmul_pkg.sv | 22 ++
 rtl/matmul_dot_sched_fifo.sv | 56 +++++
 rtl/matmul_dot_sched.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul dot-product sequencer: FSM encoding,
// vec_dot pipeline latency and the tag record layout.
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // vec_dot latency: one multiplier register plus one register per reduction level.
  function automatic int latency_of(input int depth);
    return depth + 1;
  endfunction

  // Tag record layout, MSB to LSB: {valid, row, col, last}.
  function automatic int tag_width(input int row_w, input int col_w);
    return row_w + col_w + 2;
  endfunction

endpackage

// File: rtl/matmul_dot_sched_fifo.sv
// sync_fifo: power-of-two depth FIFO with registered storage. A push is
// visible at the output the following cycle; outputs read 0 while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = push   ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(do_pop);
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule

// File: rtl/matmul_dot_sched.sv
// matmul_dot_sched: walks an MxN output tile in row-major order, issuing one
// vec_dot operation per cycle, tracks issues through the fixed-latency
// pipeline with a tag shift register and buffers results in a FIFO.
// Issue is credit-gated so a result is never dropped under back-pressure.
// Optional: MATMUL_DOT_SCHED_PERF_EN adds perf_busy / perf_stall counters.
// Handshakes: a transfer happens on a rising edge where valid && ready;
// the producer holds valid and payload stable until that edge.
module matmul_dot_sched
  import matmul_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int ROW_W       = 8,
  parameter int COL_W       = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int FLOAT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [ROW_W-1:0]       num_rows,
  input  logic [COL_W-1:0]       num_cols,
  output logic                   issue_valid,
  output logic [ROW_W-1:0]       issue_row,
  output logic [COL_W-1:0]       issue_col,
  input  logic [FLOAT_WIDTH-1:0] dot_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [FLOAT_WIDTH-1:0] res_data,
  output logic [ROW_W-1:0]       res_row,
  output logic [COL_W-1:0]       res_col,
  output logic                   res_last,
  output logic                   busy,
  output logic                   done
`ifdef MATMUL_DOT_SCHED_PERF_EN
  ,
  output logic [31:0]            perf_busy,
  output logic [31:0]            perf_stall
`endif
);

  localparam int LATENCY = latency_of(DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_W  = FLOAT_WIDTH + tag_width(ROW_W, COL_W) - 1;

  typedef struct packed {
    logic             valid;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             last;
  } tag_t;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] rows_q, rows_d, row_q, row_d;
  logic [COL_W-1:0] cols_q, cols_d, col_q, col_d;
  tag_t             tag_q [LATENCY];
  tag_t             tag_d [LATENCY];

  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   inflight;
  logic             credit, issue_fire, is_last, accept;
  logic [FIFO_W-1:0] fifo_out;

  // Count tags still travelling through the vec_dot pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + {{CNT_W{1'b0}}, tag_q[i].valid};
  end

  assign credit     = ({1'b0, fifo_count} + inflight) < (CNT_W + 1)'(FIFO_DEPTH);
  assign issue_fire = (state_q == ST_RUN) && credit;
  assign is_last    = (row_q == rows_q - ROW_W'(1)) && (col_q == cols_q - COL_W'(1));
  assign accept     = start_valid && (state_q == ST_IDLE);

  // Next-state logic: job setup, row-major index walk and drain detection.
  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          rows_d  = num_rows;
          cols_d  = num_cols;
          row_d   = '0;
          col_d   = '0;
          state_d = (num_rows == '0 || num_cols == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue_fire) begin
          if (is_last) begin
            state_d = ST_DRAIN;
          end else if (col_q == cols_q - COL_W'(1)) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Leave as the last result is popped so done follows it by one cycle.
        if (inflight == '0 && fifo_count == CNT_W'(1) && res_valid && res_ready) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Tag shift register mirroring the vec_dot pipeline.
  always_comb begin
    tag_d[0]       = '0;
    tag_d[0].valid = issue_fire;
    tag_d[0].row   = row_q;
    tag_d[0].col   = col_q;
    tag_d[0].last  = is_last;
    for (int i = 1; i < LATENCY; i++) tag_d[i] = tag_q[i-1];
  end

  // FSM, job and tag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tag_q   <= tag_d;
    end
  end

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_q[LATENCY-1].valid),
    .push_data ({dot_out, tag_q[LATENCY-1].row, tag_q[LATENCY-1].col, tag_q[LATENCY-1].last}),
    .pop       (res_ready),
    .out_valid (res_valid),
    .out_data  (fifo_out),
    .count     (fifo_count)
  );

  assign {res_data, res_row, res_col, res_last} = fifo_out;

  // start_ready is masked during reset so every output reads 0 while rst is high.
  assign start_ready = (state_q == ST_IDLE) && !rst;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign issue_valid = issue_fire;
  assign issue_row   = issue_fire ? row_q : '0;
  assign issue_col   = issue_fire ? col_q : '0;

`ifdef MATMUL_DOT_SCHED_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d, perf_stall_q, perf_stall_d;

  // Saturating activity counters, cleared when a job is accepted.
  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    if (accept) begin
      perf_busy_d  = '0;
      perf_stall_d = '0;
    end else begin
      if (busy && !(&perf_busy_q)) perf_busy_d = perf_busy_q + 32'd1;
      if (state_q == ST_RUN && !credit && !(&perf_stall_q)) perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_busy  = perf_busy_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
